// File: rtl/keypad_loader_pkg.sv
// timer_pkg: shared definitions for the keypad loader.
//   - FSM state encoding (state_t)
//   - keypad width, BCD digit width, digit counter width
//   - default DIGIT_MAX and DEBOUNCE_CYCLES values
package timer_pkg;

   localparam int KEY_W               = 10;  // one-hot keypad, digits 0..9
   localparam int BCD_W               = 4;   // width of one BCD digit
   localparam int CNT_W               = 2;   // width of digit_count
   localparam int DIGIT_MAX_DEF       = 3;   // minutes, tens_secs, secs
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_SETUP    = 3'd2,
      ST_STROBE   = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_RUN      = 3'd5
   } state_t;

endpackage

// File: rtl/keypad_loader_if.sv
// keypad_loader_if: groups the keypad/control inputs and timer-facing
// outputs of keypad_loader.
//   master modport: drives keys/startn/stopn/timer_done, observes outputs
//   slave  modport: the loader itself
//   keys        : one-hot keypad (bit n = digit n)
//   startn      : active-low start request
//   stopn       : active-low cancel request
//   timer_done  : timer reached zero
//   data        : BCD digit presented to the timer
//   load_pulse  : one-cycle shift strobe for the timer
//   loadn       : 0 = entry mode, 1 = timer counting
//   digit_count : digits loaded since last clear
//   key_error   : more than one key pressed
interface keypad_loader_if;

   logic [timer_pkg::KEY_W-1:0] keys;
   logic                        startn;
   logic                        stopn;
   logic                        timer_done;
   logic [timer_pkg::BCD_W-1:0] data;
   logic                        load_pulse;
   logic                        loadn;
   logic [timer_pkg::CNT_W-1:0] digit_count;
   logic                        key_error;

   modport master (
      output keys, startn, stopn, timer_done,
      input  data, load_pulse, loadn, digit_count, key_error
   );

   modport slave (
      input  keys, startn, stopn, timer_done,
      output data, load_pulse, loadn, digit_count, key_error
   );

endinterface

// File: rtl/keypad_loader_key_encoder.sv
// key_encoder: combinational one-hot keypad to BCD conversion.
//   keys_i   : keypad bits (bit n = digit n)
//   bcd_o    : index of the pressed key (meaningful only when single_o)
//   single_o : exactly one key pressed
//   multi_o  : more than one key pressed
module key_encoder
   import timer_pkg::*;
(
   input  logic [KEY_W-1:0] keys_i,
   output logic [BCD_W-1:0] bcd_o,
   output logic             single_o,
   output logic             multi_o
);

   logic [BCD_W-1:0] idx_term [KEY_W];
   logic [3:0]       ones;

   // Each pressed key contributes its own index; OR-ing them gives the
   // digit whenever exactly one key is down.
   for (genvar gi = 0; gi < KEY_W; gi++) begin : g_term
      assign idx_term[gi] = keys_i[gi] ? BCD_W'(gi) : '0;
   end

   always_comb begin
      bcd_o = '0;
      ones  = '0;
      for (int i = 0; i < KEY_W; i++) begin
         bcd_o = bcd_o | idx_term[i];
         ones  = ones + {3'b000, keys_i[i]};
      end
      single_o = (ones == 4'd1);
      multi_o  = (ones > 4'd1);
   end

endmodule

// File: rtl/keypad_loader.sv
// keypad_loader: debounces a one-hot keypad and shifts BCD digits into a
// countdown timer, then hands control to the timer on start.
//   CLK    : system clock (rising edge)
//   clearn : asynchronous active-low reset
//   bus    : keypad_loader_if.slave (keys, startn, stopn, timer_done in;
//            data, load_pulse, loadn, digit_count, key_error out)
// Build option: KEYPAD_LOADER_DIGIT_LIMIT_EN -- when defined, new keys are
// ignored once digit_count reaches DIGIT_MAX; otherwise further digits load
// and digit_count stays saturated.
// DEBOUNCE_CYCLES must be at least 2.
module keypad_loader
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int DIGIT_MAX       = DIGIT_MAX_DEF
) (
   input  logic           CLK,
   input  logic           clearn,
   keypad_loader_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

   state_t           state_q, state_d;
   logic [DB_W-1:0]  cnt_q,   cnt_d;
   logic [KEY_W-1:0] key_q,   key_d;
   logic [BCD_W-1:0] data_q,  data_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [BCD_W-1:0] enc_bcd;
   logic             enc_single;
   logic             enc_multi;
   logic             limit_block;

   key_encoder u_enc (
      .keys_i   (bus.keys),
      .bcd_o    (enc_bcd),
      .single_o (enc_single),
      .multi_o  (enc_multi)
   );

`ifdef KEYPAD_LOADER_DIGIT_LIMIT_EN
   assign limit_block = (count_q == CNT_W'(DIGIT_MAX));
`else
   assign limit_block = 1'b0;
`endif

   always_ff @(posedge CLK or negedge clearn) begin
      if (!clearn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      data_d  = data_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            // Cancel beats start, start beats a key press.
            if (!bus.stopn) begin
               count_d = '0;
            end else if (!bus.startn && count_q != '0) begin
               state_d = ST_RUN;
            end else if (enc_single && !limit_block) begin
               state_d = ST_DEBOUNCE;
               cnt_d   = '0;
               key_d   = bus.keys;
            end
         end
         ST_DEBOUNCE: begin
            // The IDLE cycle that saw the key counts as the first stable
            // cycle, so DEBOUNCE itself lasts DEBOUNCE_CYCLES-1 cycles.
            if (!bus.stopn) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (bus.keys != key_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 2)) begin
               state_d = ST_SETUP;
               data_d  = enc_bcd;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         ST_SETUP: begin
            if (!bus.stopn) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (!bus.stopn) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               state_d = ST_RELEASE;
               if (count_q != CNT_W'(DIGIT_MAX)) begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (!bus.stopn) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (bus.keys == '0) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.timer_done || !bus.stopn) begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The strobe is gated by stopn so a cancel in STROBE never loads.
   assign bus.data        = data_q;
   assign bus.load_pulse  = (state_q == ST_STROBE) && bus.stopn;
   assign bus.loadn       = (state_q == ST_RUN);
   assign bus.digit_count = count_q;
   assign bus.key_error   = enc_multi;

endmodule

// File: tb/tb_keypad_loader.sv
// Testbench for keypad_loader: directed sequences, a key_error vector table
// and a randomized keypad run checked against a window-scanning model.
module tb_keypad_loader;

   localparam int DB   = 4;
   localparam int DMAX = 3;
   localparam int N    = 800;

   logic CLK = 1'b0;
   logic clearn;
   always #5 CLK = ~CLK;

   keypad_loader_if bus();

   keypad_loader #(.DEBOUNCE_CYCLES(DB), .DIGIT_MAX(DMAX)) dut (
      .CLK    (CLK),
      .clearn (clearn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic       obs_lp, obs_loadn, obs_ke;
   logic [3:0] obs_data;
   logic [1:0] obs_dc;
   int         pulse_cyc[$];
   logic [3:0] pulse_dat[$];
   logic [3:0] data_log[int];

   typedef struct {
      logic [9:0] k;
      logic       exp_ke;
   } vec_t;
   vec_t tbl[8];

   logic [9:0] hist     [N];
   bit         exp_pulse[N+16];
   logic [3:0] exp_dig  [N+16];
   logic [3:0] exp_data [N];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   function automatic logic [9:0] key(input int d);
      logic [9:0] one;
      one = 10'd1;
      return one << d;
   endfunction

   function automatic logic [3:0] digit_of(input logic [9:0] k);
      for (int i = 0; i < 10; i++) if (k[i]) return 4'(i);
      return 4'd0;
   endfunction

   // One clock cycle: drive inputs after the edge, then sample outputs.
   task automatic step(input logic [9:0] k, input logic st_n, input logic sp_n, input logic td);
      @(posedge CLK);
      #1;
      bus.keys = k; bus.startn = st_n; bus.stopn = sp_n; bus.timer_done = td;
      #1;
      obs_lp    = bus.load_pulse;
      obs_data  = bus.data;
      obs_loadn = bus.loadn;
      obs_dc    = bus.digit_count;
      obs_ke    = bus.key_error;
      data_log[cyc] = obs_data;
      if (obs_lp) begin
         pulse_cyc.push_back(cyc);
         pulse_dat.push_back(obs_data);
      end
      cyc++;
   endtask

   task automatic hold(input logic [9:0] k, input int n);
      repeat (n) step(k, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic load_digit(input int d);
      hold(key(d), 6);
      hold(10'd0, 2);
   endtask

   task automatic do_reset();
      clearn = 1'b0;
      bus.keys = '0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.timer_done = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_data",  bus.data, 0);
      check("rst_lp",    bus.load_pulse, 0);
      check("rst_loadn", bus.loadn, 0);
      check("rst_dc",    bus.digit_count, 0);
      check("rst_kerr",  bus.key_error, 0);
      @(negedge CLK);
      clearn = 1'b1;
      pulse_cyc.delete();
      pulse_dat.delete();
   endtask

   initial begin
      int base, n0, p;
      bit found;

      // ---- single digit load with setup/hold of data ----
      do_reset();
      base = cyc;
      hold(key(2), 6);
      hold(10'd0, 3);
      check("p1_npulse", pulse_cyc.size(), 1);
      if (pulse_cyc.size() == 1) begin
         p = pulse_cyc[0];
         check("p1_latency", p - base, DB + 1);
         check("p1_setup",   data_log[p-1], 2);
         check("p1_data",    pulse_dat[0], 2);
         check("p1_hold",    data_log[p+1], 2);
      end
      check("p1_dc", obs_dc, 1);
      $display("txn: key 2 load, pulses=%0d dc=%0d", pulse_cyc.size(), obs_dc);

      // ---- 2,1,7 then start, keys ignored in RUN, timer_done ----
      load_digit(1);
      load_digit(7);
      check("p3_npulse", pulse_cyc.size(), 3);
      if (pulse_cyc.size() == 3) begin
         check("p3_d0", pulse_dat[0], 2);
         check("p3_d1", pulse_dat[1], 1);
         check("p3_d2", pulse_dat[2], 7);
      end
      check("p3_dc", obs_dc, 3);
      step(10'd0, 1'b0, 1'b1, 1'b0);
      step(10'd0, 1'b1, 1'b1, 1'b0);
      check("run_loadn", obs_loadn, 1);
      hold(key(4), 8);
      check("run_keys_ignored", pulse_cyc.size(), 3);
      check("run_loadn_held", obs_loadn, 1);
      hold(10'd0, 1);
      step(10'd0, 1'b1, 1'b1, 1'b1);
      step(10'd0, 1'b1, 1'b1, 1'b0);
      check("done_loadn", obs_loadn, 0);
      check("done_dc", obs_dc, 0);
      $display("txn: 2,1,7 + start + timer_done, loadn=%0d dc=%0d", obs_loadn, obs_dc);

      // ---- start and key together: start wins; stopn exits RUN ----
      load_digit(5);
      n0 = pulse_cyc.size();
      step(key(6), 1'b0, 1'b1, 1'b0);
      hold(key(6), 8);
      check("startwin_loadn", obs_loadn, 1);
      check("startwin_nopulse", pulse_cyc.size() - n0, 0);
      step(10'd0, 1'b1, 1'b0, 1'b0);
      step(10'd0, 1'b1, 1'b1, 1'b0);
      check("stop_run_loadn", obs_loadn, 0);
      check("stop_run_dc", obs_dc, 0);
      $display("txn: start vs key, stop in RUN, dc=%0d", obs_dc);

      // ---- short press and double press ----
      n0 = pulse_cyc.size();
      hold(key(5), 2);
      hold(10'd0, 6);
      check("short_nopulse", pulse_cyc.size() - n0, 0);
      hold(key(3) | key(4), 8);
      check("multi_kerr", obs_ke, 1);
      hold(10'd0, 2);
      check("multi_nopulse", pulse_cyc.size() - n0, 0);
      check("multi_kerr_clr", obs_ke, 0);
      $display("txn: short press + keys 3&4, pulses=%0d", pulse_cyc.size() - n0);

      // ---- long hold loads once ----
      n0 = pulse_cyc.size();
      hold(key(9), 50);
      hold(10'd0, 2);
      check("long_npulse", pulse_cyc.size() - n0, 1);
      check("long_dc", obs_dc, 1);
      $display("txn: key 9 x50, pulses=%0d", pulse_cyc.size() - n0);

      // ---- stopn during DEBOUNCE ----
      n0 = pulse_cyc.size();
      hold(key(3), 2);
      step(key(3), 1'b1, 1'b0, 1'b0);
      hold(10'd0, 6);
      check("stop_db_nopulse", pulse_cyc.size() - n0, 0);
      check("stop_db_dc", obs_dc, 0);
      $display("txn: stop in debounce, dc=%0d", obs_dc);

      // ---- minimum back-to-back interval ----
      n0 = pulse_cyc.size();
      hold(key(3), 6);
      hold(10'd0, 1);
      hold(key(4), 6);
      hold(10'd0, 2);
      check("interval_npulse", pulse_cyc.size() - n0, 2);
      if (pulse_cyc.size() - n0 == 2)
         check("interval_cycles", pulse_cyc[n0+1] - pulse_cyc[n0], DB + 3);
      $display("txn: back-to-back loads, pulses=%0d", pulse_cyc.size() - n0);

      // ---- fourth digit ----
      do_reset();
      load_digit(2); load_digit(1); load_digit(7);
      n0 = pulse_cyc.size();
      hold(key(8), 6);
      hold(10'd0, 2);
`ifdef KEYPAD_LOADER_DIGIT_LIMIT_EN
      check("d4_npulse", pulse_cyc.size() - n0, 0);
`else
      check("d4_npulse", pulse_cyc.size() - n0, 1);
      if (pulse_cyc.size() - n0 == 1) check("d4_data", pulse_dat[n0], 8);
`endif
      check("d4_dc", obs_dc, 3);
      $display("txn: fourth digit, pulses=%0d dc=%0d", pulse_cyc.size() - n0, obs_dc);

      // ---- reset during STROBE ----
      do_reset();
      load_digit(2);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(key(5), 1'b1, 1'b1, 1'b0);
         if (obs_lp) found = 1'b1;
      end
      check("strobe_seen", found, 1);
      #1 clearn = 1'b0;
      #1;
      check("midrst_lp",    bus.load_pulse, 0);
      check("midrst_data",  bus.data, 0);
      check("midrst_dc",    bus.digit_count, 0);
      check("midrst_loadn", bus.loadn, 0);
      bus.keys = '0;
      @(negedge CLK);
      clearn = 1'b1;
      step(10'd0, 1'b0, 1'b1, 1'b0);
      hold(10'd0, 3);
      check("start_empty_loadn", obs_loadn, 0);
      $display("txn: reset in strobe, then start with no digits, loadn=%0d", obs_loadn);

      // ---- key_error vector table ----
      tbl[0] = '{10'b0000000000, 1'b0};
      tbl[1] = '{10'b0000000001, 1'b0};
      tbl[2] = '{10'b1000000000, 1'b0};
      tbl[3] = '{10'b0000000011, 1'b1};
      tbl[4] = '{10'b1111111111, 1'b1};
      tbl[5] = '{10'b1000000001, 1'b1};
      tbl[6] = '{10'b0000100000, 1'b0};
      tbl[7] = '{10'b0000011000, 1'b1};
      for (int i = 0; i < 8; i++) begin
         n0 = pulse_cyc.size();
         step(tbl[i].k, 1'b1, 1'b1, 1'b0);
         check($sformatf("tbl%0d_kerr", i), obs_ke, tbl[i].exp_ke);
         hold(10'd0, DB + 4);
         check($sformatf("tbl%0d_nopulse", i), pulse_cyc.size() - n0, 0);
         $display("txn: vector %0d keys=%b key_error=%0d", i, tbl[i].k, obs_ke);
      end

      // ---- randomized keypad run against a window-scanning model ----
      do_reset();
      begin
         int c, len, a, b, r, j, loads;
         logic [9:0] kv;
         logic [3:0] cur;
         c = 0;
         while (c < N - 20) begin
            r = $urandom_range(0, 9);
            if (r < 3) kv = '0;
            else if (r < 9) kv = key($urandom_range(0, 9));
            else begin
               a  = $urandom_range(0, 9);
               b  = (a + 1 + $urandom_range(0, 8)) % 10;
               kv = key(a) | key(b);
            end
            len = $urandom_range(1, 8);
            for (int i = 0; i < len && c < N - 20; i++) begin
               hist[c] = kv;
               c++;
            end
         end
         for (int i = N - 20; i < N; i++) hist[i] = '0;
         for (int i = 0; i < N + 16; i++) begin exp_pulse[i] = 1'b0; exp_dig[i] = '0; end

         // A single key seen while idle loads if it stays identical for DB
         // cycles; the pulse lands DB+1 cycles later, then the keypad must
         // read empty before another key is considered.
         c = 0;
         loads = 0;
         while (c < N) begin
`ifdef KEYPAD_LOADER_DIGIT_LIMIT_EN
            if ($countones(hist[c]) == 1 && loads < DMAX) begin
`else
            if ($countones(hist[c]) == 1) begin
`endif
               j = c + 1;
               while (j < c + DB && j < N && hist[j] == hist[c]) j++;
               if (j == c + DB) begin
                  exp_pulse[c+DB+1] = 1'b1;
                  exp_dig[c+DB+1]   = digit_of(hist[c]);
                  loads++;
                  r = c + DB + 2;
                  while (r < N && hist[r] != '0) r++;
                  c = r + 1;
               end else begin
                  c = j + 1;
               end
            end else begin
               c++;
            end
         end
         cur = '0;
         for (int i = 0; i < N; i++) begin
            if (exp_pulse[i+1]) cur = exp_dig[i+1];
            exp_data[i] = cur;
         end

         n0 = pulse_cyc.size();
         for (int i = 0; i < N; i++) begin
            step(hist[i], 1'b1, 1'b1, 1'b0);
            check($sformatf("rnd_pulse@%0d", i), obs_lp, exp_pulse[i]);
            check($sformatf("rnd_data@%0d", i), obs_data, exp_data[i]);
            check($sformatf("rnd_kerr@%0d", i), obs_ke, $countones(hist[i]) > 1);
         end
         check("rnd_dc", obs_dc, (loads > DMAX) ? DMAX : loads);
         $display("txn: random run %0d cycles, model loads=%0d, observed pulses=%0d",
                  N, loads, pulse_cyc.size() - n0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
